miriscv_dmem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters: port A (core LSU, fed by the memory request stage) and port B (secondary master, e.g. debug/DMA).
- Memory side adds a grant/rvalid handshake with up to MAX_OUTSTANDING in-order transactions.
- Internal owner FIFO routes each response back to the requester that issued it.
- Produces a stall request so the memory request stage can hold while the port is busy or ungranted.

---
 rtl/miriscv_dmem_arbiter_if.sv | 37 +++
 rtl/miriscv_dmem_arbiter.sv | 108 ++++++++++
 tb/tb_miriscv_dmem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/miriscv_dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the data memory arbiter.
// slave = arbiter view; master = the environment (both requesters plus memory).
interface miriscv_dmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              a_req_i, a_we_i, a_gnt_o, a_rvalid_o, a_stall_req_o;
  logic [XLEN/8-1:0] a_be_i;
  logic [XLEN-1:0]   a_addr_i, a_wdata_i;
  logic              b_req_i, b_we_i, b_gnt_o, b_rvalid_o, b_stall_req_o;
  logic [XLEN/8-1:0] b_be_i;
  logic [XLEN-1:0]   b_addr_i, b_wdata_i;
  logic [XLEN-1:0]   rdata_o;
  logic              data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [XLEN/8-1:0] data_be_o;
  logic [XLEN-1:0]   data_addr_o, data_wdata_o, data_rdata_i;
  logic              busy_o, protocol_err_o;

  modport slave (
    input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
    input  b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output a_gnt_o, a_rvalid_o, a_stall_req_o,
    output b_gnt_o, b_rvalid_o, b_stall_req_o,
    output rdata_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output busy_o, protocol_err_o
  );

  modport master (
    output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
    output b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  a_gnt_o, a_rvalid_o, a_stall_req_o,
    input  b_gnt_o, b_rvalid_o, b_stall_req_o,
    input  rdata_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  busy_o, protocol_err_o
  );
endinterface

// File: rtl/miriscv_dmem_arbiter.sv
// Two-port round-robin arbiter onto one data memory port with gnt/rvalid
// handshake, bounded in-order outstanding transactions and response routing.
module miriscv_dmem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  miriscv_dmem_arbiter_if.slave        bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic                       prio_q, prio_d;
  logic                       lock_q, lock_d;
  logic                       lock_own_q, lock_own_d;
  logic                       perr_q, perr_d;

  logic sel, sel_req, can_issue, req, accept, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel = PORT_A;
    if (lock_q)                          sel = lock_own_q;
    else if (bus.a_req_i && bus.b_req_i) sel = prio_q;
    else if (bus.b_req_i)                sel = PORT_B;
  end

  assign sel_req   = (sel == PORT_B) ? bus.b_req_i : bus.a_req_i;
  // A full count blocks issue even when a response retires in the same cycle.
  assign can_issue = count_q < MAX_CNT;
  assign req       = can_issue & sel_req;
  assign accept    = req & bus.data_gnt_i;
  assign pop       = bus.data_rvalid_i & (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  assign bus.data_req_o   = req;
  assign bus.data_we_o    = req & ((sel == PORT_B) ? bus.b_we_i : bus.a_we_i);
  assign bus.data_be_o    = req ? ((sel == PORT_B) ? bus.b_be_i    : bus.a_be_i)    : '0;
  assign bus.data_addr_o  = req ? ((sel == PORT_B) ? bus.b_addr_i  : bus.a_addr_i)  : '0;
  assign bus.data_wdata_o = req ? ((sel == PORT_B) ? bus.b_wdata_i : bus.a_wdata_i) : '0;

  assign bus.a_gnt_o       = accept & (sel == PORT_A);
  assign bus.b_gnt_o       = accept & (sel == PORT_B);
  assign bus.a_stall_req_o = bus.a_req_i & ~bus.a_gnt_o;
  assign bus.b_stall_req_o = bus.b_req_i & ~bus.b_gnt_o;
  assign bus.a_rvalid_o    = pop & (head == PORT_A);
  assign bus.b_rvalid_o    = pop & (head == PORT_B);
  assign bus.rdata_o       = bus.data_rdata_i;
  assign bus.busy_o        = count_q != '0;
  assign bus.protocol_err_o = perr_q;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_d     = fifo_q;
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    perr_d     = perr_q | (bus.data_rvalid_i & (count_q == '0));
    if (accept) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      prio_d           = ~sel;
      lock_d           = 1'b0;
    end else if (req) begin
      // Pin the ungranted requester so the memory sees a stable request.
      lock_d     = 1'b1;
      lock_own_d = sel;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_q     <= '0;
      prio_q     <= PORT_A;
      lock_q     <= 1'b0;
      lock_own_q <= PORT_A;
      perr_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      perr_q     <= perr_d;
    end
  end
endmodule

// File: tb/tb_miriscv_dmem_arbiter.sv
// Directed bench: expected response owners are queued on grant and popped when
// the memory response is driven back.
module tb_miriscv_dmem_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  miriscv_dmem_arbiter_if #(.XLEN(XLEN)) bus();
  miriscv_dmem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(2)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_req_i = 0; bus.a_we_i = 0; bus.a_be_i = '0; bus.a_addr_i = '0; bus.a_wdata_i = '0;
    bus.b_req_i = 0; bus.b_we_i = 0; bus.b_be_i = '0; bus.b_addr_i = '0; bus.b_wdata_i = '0;
    bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = '0;
  endtask

  // Pops the expected owner of the response currently driven on data_rvalid_i.
  task automatic rsp_chk(input string tag);
    bit own;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: observed=response expected=no pending transaction", tag);
    end else begin
      own = exp_q.pop_front();
      chk({tag, "_a_rvalid"}, 32'(bus.a_rvalid_o), 32'(own == 1'b0));
      chk({tag, "_b_rvalid"}, 32'(bus.b_rvalid_o), 32'(own == 1'b1));
    end
  endtask

  task automatic do_reset();
    next(); arstn = 0; idle();
    next(); arstn = 1;
    exp_q.delete();
  endtask

  initial begin
    arstn = 0;
    idle();
    next(); next();
    chk("rst_data_req", 32'(bus.data_req_o), 0);
    chk("rst_gnt", {30'd0, bus.a_gnt_o, bus.b_gnt_o}, 0);
    chk("rst_stall", {30'd0, bus.a_stall_req_o, bus.b_stall_req_o}, 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_perr", 32'(bus.protocol_err_o), 0);
    chk("rst_addr", bus.data_addr_o, 0);
    arstn = 1;

    // Single A read
    next(); bus.a_req_i = 1; bus.a_addr_i = 32'h100; bus.a_be_i = 4'hF; bus.data_gnt_i = 1; #1;
    chk("t1_a_gnt", 32'(bus.a_gnt_o), 1);
    chk("t1_req", 32'(bus.data_req_o), 1);
    chk("t1_addr", bus.data_addr_o, 32'h100);
    chk("t1_stall", 32'(bus.a_stall_req_o), 0);
    exp_q.push_back(1'b0);
    next(); idle(); #1;
    chk("t1_busy", 32'(bus.busy_o), 1);
    next(); bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hDEADBEEF; #1;
    rsp_chk("t1");
    chk("t1_rdata", bus.rdata_o, 32'hDEADBEEF);
    next(); idle(); #1;
    chk("t1_busy_end", 32'(bus.busy_o), 0);

    // Lock: prio is now B; A stalls ungranted, B joining must not steal the port
    next(); bus.a_req_i = 1; bus.a_addr_i = 32'h400; bus.a_we_i = 1; bus.a_wdata_i = 32'h55;
    bus.a_be_i = 4'hF; #1;
    chk("lk0_req", 32'(bus.data_req_o), 1);
    chk("lk0_stall", 32'(bus.a_stall_req_o), 1);
    chk("lk0_addr", bus.data_addr_o, 32'h400);
    for (int i = 1; i < 3; i++) begin
      next(); bus.b_req_i = 1; bus.b_addr_i = 32'h500; #1;
      chk("lk_addr", bus.data_addr_o, 32'h400);
      chk("lk_a_stall", 32'(bus.a_stall_req_o), 1);
      chk("lk_b_gnt", 32'(bus.b_gnt_o), 0);
      chk("lk_b_stall", 32'(bus.b_stall_req_o), 1);
    end
    next(); bus.data_gnt_i = 1; #1;
    chk("lk3_a_gnt", 32'(bus.a_gnt_o), 1);
    chk("lk3_b_gnt", 32'(bus.b_gnt_o), 0);
    chk("lk3_we", 32'(bus.data_we_o), 1);
    chk("lk3_wdata", bus.data_wdata_o, 32'h55);
    exp_q.push_back(1'b0);
    next(); bus.a_req_i = 0; bus.a_we_i = 0; #1;
    chk("lk4_b_gnt", 32'(bus.b_gnt_o), 1);
    chk("lk4_addr", bus.data_addr_o, 32'h500);
    chk("lk4_we", 32'(bus.data_we_o), 0);
    exp_q.push_back(1'b1);
    next(); bus.b_req_i = 0; bus.data_rvalid_i = 1; bus.data_rdata_i = 32'h1; #1;
    rsp_chk("lk_r0");
    next(); bus.data_rdata_i = 32'h2; #1;
    rsp_chk("lk_r1");
    chk("lk_rdata", bus.rdata_o, 32'h2);
    next(); idle(); #1;
    chk("lk_busy_end", 32'(bus.busy_o), 0);

    // Round robin after reset, with accept and response in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bit exp_own;
      next();
      bus.a_req_i = 1; bus.a_addr_i = 32'h200;
      bus.b_req_i = 1; bus.b_addr_i = 32'h300;
      bus.data_gnt_i = 1; bus.data_rvalid_i = (i > 0); bus.data_rdata_i = 32'(i); #1;
      exp_own = bit'(i % 2);
      chk("rr_a_gnt", 32'(bus.a_gnt_o), 32'(exp_own == 1'b0));
      chk("rr_b_gnt", 32'(bus.b_gnt_o), 32'(exp_own == 1'b1));
      chk("rr_addr", bus.data_addr_o, exp_own ? 32'h300 : 32'h200);
      if (i > 0) begin
        rsp_chk("rr");
        chk("rr_busy", 32'(bus.busy_o), 1);
      end
      exp_q.push_back(exp_own);
    end
    next(); idle(); bus.data_rvalid_i = 1; #1;
    rsp_chk("rr_last");
    next(); idle(); #1;
    chk("rr_busy_end", 32'(bus.busy_o), 0);

    // Full outstanding count blocks issue, even with a response in flight
    next(); bus.a_req_i = 1; bus.a_addr_i = 32'h600; bus.data_gnt_i = 1; #1;
    chk("fc0_gnt", 32'(bus.a_gnt_o), 1);
    exp_q.push_back(1'b0);
    next(); #1;
    chk("fc1_gnt", 32'(bus.a_gnt_o), 1);
    exp_q.push_back(1'b0);
    next(); bus.data_rvalid_i = 1; #1;
    chk("fc2_req", 32'(bus.data_req_o), 0);
    chk("fc2_stall", 32'(bus.a_stall_req_o), 1);
    chk("fc2_gnt", 32'(bus.a_gnt_o), 0);
    chk("fc2_addr", bus.data_addr_o, 0);
    rsp_chk("fc2");
    next(); bus.data_rvalid_i = 0; #1;
    chk("fc3_req", 32'(bus.data_req_o), 1);
    chk("fc3_gnt", 32'(bus.a_gnt_o), 1);
    exp_q.push_back(1'b0);
    next(); bus.a_req_i = 0; bus.data_rvalid_i = 1; #1;
    rsp_chk("fc4");
    next(); #1;
    rsp_chk("fc5");
    next(); idle(); #1;
    chk("fc_busy_end", 32'(bus.busy_o), 0);

    // Spurious response
    next(); bus.data_rvalid_i = 1; #1;
    chk("sp_a_rvalid", 32'(bus.a_rvalid_o), 0);
    chk("sp_b_rvalid", 32'(bus.b_rvalid_o), 0);
    chk("sp_perr_pre", 32'(bus.protocol_err_o), 0);
    next(); bus.data_rvalid_i = 0; #1;
    chk("sp_perr", 32'(bus.protocol_err_o), 1);
    chk("sp_busy", 32'(bus.busy_o), 0);
    next(); #1;
    chk("sp_perr_sticky", 32'(bus.protocol_err_o), 1);

    // Reset mid-transaction
    next(); bus.b_req_i = 1; bus.data_gnt_i = 1; #1;
    chk("mr_b_gnt", 32'(bus.b_gnt_o), 1);
    next(); bus.b_req_i = 0; #1;
    chk("mr_busy", 32'(bus.busy_o), 1);
    arstn = 0; #1;
    chk("mr_busy_rst", 32'(bus.busy_o), 0);
    chk("mr_perr_rst", 32'(bus.protocol_err_o), 0);
    next(); arstn = 1; exp_q.delete();
    next(); bus.data_rvalid_i = 1; #1;
    chk("mr_late_a", 32'(bus.a_rvalid_o), 0);
    chk("mr_late_b", 32'(bus.b_rvalid_o), 0);
    next(); bus.data_rvalid_i = 0; bus.a_req_i = 1; bus.b_req_i = 1; #1;
    chk("mr_prio_a", 32'(bus.a_gnt_o), 1);
    chk("mr_prio_b", 32'(bus.b_gnt_o), 0);
    chk("mr_perr_late", 32'(bus.protocol_err_o), 1);
    next(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
